jtframe_ioctl_upload: RTL and testbench
=======================================

Name: jtframe_ioctl_upload

Overview:
- SPI-side transmitter for the ioctl upload path (FPGA to SD card, e.g. NVRAM/hiscore save); the counterpart of the ioctl download receiver in the MiST base.
- Sits between the ARM IO controller SPI pins and the game's ioctl read port (ioctl_addr / ioctl_data2sd).
- Decodes an upload command byte, walks the game's RAM address space, fetches bytes with a fixed-latency read and shifts them out MSB first on SPI_DO.
- Single fast clock: SPI lines are oversampled, not used as clocks.

Parameters:
- AW, 25, ioctl address width.
- CMD_UPLOAD, 8'h56, command byte that starts an upload.
- RD_LAT, 2, clk cycles from ioctl_rd pulse to valid ioctl_data2sd (1..7).
- UPLOAD_SIZE, 1024, bytes served before padding; used only with the optional feature.

Ports:
- clk  in  1  system clock; must be at least 4x SPI_SCK.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from ARM (asynchronous).
- spi_ss  in  1  SPI select, active low (asynchronous).
- spi_di  in  1  SPI data from ARM (asynchronous).
- spi_do  out  1  SPI data to ARM.
- spi_do_oe  out  1  drive enable for spi_do; the top level tristates SPI_DO when low.
- ioctl_addr  out  AW  read address into game RAM.
- ioctl_rd  out  1  one-cycle read strobe.
- ioctl_data2sd  in  8  read data, valid RD_LAT cycles after ioctl_rd.
- uploading  out  1  high while an upload transfer is active.
- byte_cnt  out  AW  bytes completed in the current transfer.

Behaviour:
- Reset values: spi_do=1, spi_do_oe=0, ioctl_addr=0, ioctl_rd=0, uploading=0, byte_cnt=0. FSM in IDLE, shifters cleared.
- Synchronisation and edge detect:
  - spi_sck, spi_ss and spi_di each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised signals.
  - SPI mode 0: spi_di sampled on SCK rise; spi_do updated on SCK fall.
- FSM states IDLE, CMD, SEND, SKIP.
- IDLE:
  - On ss falling: go to CMD.
  - Clear the bit counter, ioctl_addr and byte_cnt.
  - Issue a prefetch: ioctl_rd pulses for one cycle with ioctl_addr=0.
- CMD:
  - Shift spi_di into an 8-bit register on each SCK rise.
  - After the 8th rise: if byte == CMD_UPLOAD, go to SEND, load the prefetched byte into tx_shift and set uploading=1. Otherwise go to SKIP.
- SEND:
  - spi_do_oe=1.
  - On each SCK fall: spi_do=tx_shift[7] and tx_shift shifts left.
  - After the 8th rise of a data byte:
    - byte_cnt and ioctl_addr increment (AW-bit wrap-around: all-ones goes to 0).
    - The next prefetched byte loads into tx_shift.
    - A new ioctl_rd pulse is issued for the new address.
  - Prefetch data is captured into a holding register exactly RD_LAT cycles after ioctl_rd.
  - With clk at 4x SCK and RD_LAT at most 7, the holding register is valid before the next byte boundary. Timing faster than this is outside spec.
- SKIP: spi_do_oe=0; ignore all SCK activity.
- Any state, ss rising (deselect):
  - Go to IDLE immediately; uploading=0 and spi_do_oe=0 on the next cycle.
  - An in-flight read completes but its data is discarded.
  - byte_cnt holds its value until the next ss fall.
- Partial byte when ss rises: byte_cnt is not incremented.
- SS rise and SCK edge in the same cycle: the deselect wins.
- Reset mid-transfer: all outputs return to reset values asynchronously.
- spi_do idles at 1 whenever spi_do_oe=0.

Optional Feature:
- Macro: JTFRAME_UPLOAD_LIMIT_EN.
- Defined:
  - Once byte_cnt reaches UPLOAD_SIZE, ioctl_addr stops incrementing and no further ioctl_rd is issued.
  - Subsequent bytes shift out as 8'hFF.
  - byte_cnt saturates at UPLOAD_SIZE.
- Undefined: no limit; the address wraps at 2^AW and UPLOAD_SIZE is ignored.

Test Plan:
- Basic upload: RAM[0..3]=A5,3C,00,FF; ss low, send 8'h56, clock 32 bits.
  - Required: spi_do yields A5 3C 00 FF MSB first.
  - Required: byte_cnt=4 and ioctl_addr=4 after the last byte; uploading=1 throughout.
- Wrong command: send 8'h54, clock 16 more bits.
  - Required: spi_do_oe=0, no ioctl_rd after the initial prefetch, uploading=0.
- Abort mid-byte: deselect after 3 bits of the second data byte.
  - Required: byte_cnt=1, uploading=0 within 3 clk.
  - Required: the next transfer restarts at ioctl_addr=0.
- Latency sweep: RD_LAT=1 and RD_LAT=7 with clk = 4x SCK, 16 random bytes.
  - Required: every byte matches RAM contents.
- Limit, with JTFRAME_UPLOAD_LIMIT_EN and UPLOAD_SIZE=2: clock 4 data bytes.
  - Required: RAM[0], RAM[1], FF, FF out; ioctl_addr stays 2; byte_cnt=2.
- Async reset asserted during SEND.
  - Required: spi_do=1, spi_do_oe=0, ioctl_rd=0 the same cycle.
  - Required: a subsequent upload works normally.

Source files
------------

// File: rtl/jtframe_ioctl_upload.sv
// SPI-side ioctl upload transmitter: decodes the upload command from the ARM
// IO controller, walks game RAM through the ioctl read port and shifts the
// bytes out MSB first on spi_do (SPI mode 0, SPI lines oversampled by clk).
// Latency: SPI edges act 3 clk after they happen (2-flop sync + register);
// the RAM fetch runs one byte ahead so RD_LAT (1..7) is hidden from the host.
// Backpressure: none; the ARM master paces everything through spi_sck, and
// clk must be at least 4x spi_sck.
//
// Ports:
//   clk, rst                     system clock, async active-high reset
//   spi_sck, spi_ss, spi_di      asynchronous SPI inputs from the ARM
//   spi_do, spi_do_oe            SPI data out and its tristate enable
//   ioctl_addr, ioctl_rd         game RAM read address and one-cycle strobe
//   ioctl_data2sd                read data, valid RD_LAT clk after ioctl_rd
//   uploading, byte_cnt          transfer active flag, completed byte count
//
// Optional: define JTFRAME_UPLOAD_LIMIT_EN to stop fetching after UPLOAD_SIZE
// bytes and pad the rest of the transfer with 8'hFF.

module jtframe_ioctl_upload #(
   parameter int         AW          = 25,
   parameter logic [7:0] CMD_UPLOAD  = 8'h56,
   parameter int         RD_LAT      = 2,
   parameter int         UPLOAD_SIZE = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spi_sck,
   input  logic          spi_ss,
   input  logic          spi_di,
   output logic          spi_do,
   output logic          spi_do_oe,
   output logic [AW-1:0] ioctl_addr,
   output logic          ioctl_rd,
   input  logic [7:0]    ioctl_data2sd,
   output logic          uploading,
   output logic [AW-1:0] byte_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_SKIP = 2'd3;

   localparam logic [AW:0] LIMIT = (AW+1)'(UPLOAD_SIZE);

   // ---------------------------------------------------------------------
   // Synchronisers: bits [1:0] are the 2-flop sync, bit [2] is the previous
   // synchronised value used for edge detection. SS idles high (deselected)
   // so reset release never looks like a select.
   // ---------------------------------------------------------------------
   logic [2:0] sck_q;
   logic [2:0] ss_q;
   logic [1:0] di_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q <= 3'b000;
         ss_q  <= 3'b111;
         di_q  <= 2'b00;
      end else begin
         sck_q <= {sck_q[1:0], spi_sck};
         ss_q  <= {ss_q[1:0], spi_ss};
         di_q  <= {di_q[0], spi_di};
      end
   end

   logic sck_rise, sck_fall, ss_rise, ss_fall, di_s;
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ss_rise  = ss_q[1] & ~ss_q[2];
   assign ss_fall  = ~ss_q[1] & ss_q[2];
   assign di_s     = di_q[1];

   // ---------------------------------------------------------------------
   // Main state
   // ---------------------------------------------------------------------
   logic [1:0]        state_q, state_d;
   logic [2:0]        bit_q, bit_d;
   logic [6:0]        cmd_q, cmd_d;     // first 7 command bits; the 8th is live
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        hold_q, hold_d;   // prefetched byte waiting for tx_q
   logic [RD_LAT-1:0] rdp_q, rdp_d;     // read strobe delay line
   logic              do_q, do_d;
   logic              oe_q, oe_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              up_q, up_d;
   logic [AW-1:0]     cnt_q, cnt_d;

   logic [RD_LAT:0]   rd_line;
   logic [7:0]        cmd_next;
   logic              at_limit;         // no more fetches, count saturated
   logic              next_pad;         // byte about to load is past the limit

   assign rd_line  = {rdp_q, rd_q};
   assign cmd_next = {cmd_q, di_s};

`ifdef JTFRAME_UPLOAD_LIMIT_EN
   assign at_limit = {1'b0, cnt_q} >= LIMIT;
   assign next_pad = ({1'b0, cnt_q} + (AW+1)'(1)) >= LIMIT;
`else
   logic unused_limit;
   assign unused_limit = ^LIMIT;
   assign at_limit = 1'b0;
   assign next_pad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cmd_d   = cmd_q;
      tx_d    = tx_q;
      hold_d  = hold_q;
      rdp_d   = rd_line[RD_LAT-1:0];
      do_d    = do_q;
      oe_d    = oe_q;
      addr_d  = addr_q;
      rd_d    = 1'b0;
      up_d    = up_q;
      cnt_d   = cnt_q;

      // The read data is on the bus exactly RD_LAT cycles after the strobe
      if (rdp_q[RD_LAT-1]) hold_d = ioctl_data2sd;

      if (ss_rise) begin
         // Deselect beats everything, including a same-cycle SCK edge.
         // Flushing the delay line drops the data of any read in flight.
         state_d = ST_IDLE;
         bit_d   = 3'd0;
         oe_d    = 1'b0;
         do_d    = 1'b1;
         up_d    = 1'b0;
         rdp_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               oe_d = 1'b0;
               do_d = 1'b1;
               if (ss_fall) begin
                  state_d = ST_CMD;
                  bit_d   = 3'd0;
                  addr_d  = '0;
                  cnt_d   = '0;
                  rd_d    = 1'b1;   // prefetch byte 0 while the command arrives
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  cmd_d = cmd_next[6:0];
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     if (cmd_next == CMD_UPLOAD) begin
                        state_d = ST_SEND;
                        tx_d    = hold_q;
                        up_d    = 1'b1;
                        oe_d    = 1'b1;
                     end else begin
                        state_d = ST_SKIP;
                     end
                  end
               end
            end
            ST_SEND: begin
               oe_d = 1'b1;
               if (sck_fall) begin
                  do_d = tx_q[7];
                  tx_d = {tx_q[6:0], 1'b0};
               end
               if (sck_rise) begin
                  bit_d = bit_q + 3'd1;
                  // First bit of a byte: the byte in tx_q is committed, so
                  // start fetching its successor. This leaves a full byte
                  // time for the read to land in hold_q.
                  if (bit_q == 3'd0 && !at_limit) begin
                     addr_d = addr_q + 1'b1;
                     rd_d   = 1'b1;
                  end
                  if (bit_q == 3'd7) begin
                     if (!at_limit) cnt_d = cnt_q + 1'b1;
                     tx_d = next_pad ? 8'hFF : hold_q;
                  end
               end
            end
            default: begin   // ST_SKIP: wrong command, stay off the bus
               oe_d = 1'b0;
               do_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bit_q   <= 3'd0;
         cmd_q   <= 7'd0;
         tx_q    <= 8'd0;
         hold_q  <= 8'd0;
         rdp_q   <= '0;
         do_q    <= 1'b1;
         oe_q    <= 1'b0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         up_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         cmd_q   <= cmd_d;
         tx_q    <= tx_d;
         hold_q  <= hold_d;
         rdp_q   <= rdp_d;
         do_q    <= do_d;
         oe_q    <= oe_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         up_q    <= up_d;
         cnt_q   <= cnt_d;
      end
   end

   // spi_do is forced high whenever the pin is not driven
   assign spi_do     = do_q | ~oe_q;
   assign spi_do_oe  = oe_q;
   assign ioctl_addr = addr_q;
   assign ioctl_rd   = rd_q;
   assign uploading  = up_q;
   assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_jtframe_ioctl_upload.sv
// Directed bench for jtframe_ioctl_upload: three instances share the SPI
// lines and differ only in RD_LAT (2, 1, 7); each has its own RAM read
// model that drives garbage outside the valid data window.
// clk = 10 ns, SCK = 40 ns (clk is 4x SCK); SPI edges land on clk falls.

module tb_jtframe_ioctl_upload;

   localparam int AW = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic spi_sck = 1'b0;
   logic spi_ss = 1'b1;
   logic spi_di = 1'b0;

   logic          spi_do_w    [3];
   logic          spi_do_oe_w [3];
   logic [AW-1:0] addr_w      [3];
   logic          rd_w        [3];
   logic [7:0]    d2sd_w      [3];
   logic          up_w        [3];
   logic [AW-1:0] cnt_w       [3];

   logic [7:0] mem [256];
   logic [7:0] rxb [3];

   int n_chk  = 0;
   int n_fail = 0;
   int rd_cnt = 0;
   int rd_base;
   logic oe_seen;
   logic up_all;
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
         logic       vp [8];
         logic [7:0] ap [8];

         jtframe_ioctl_upload #(
            .AW(AW), .CMD_UPLOAD(8'h56), .RD_LAT(LAT), .UPLOAD_SIZE(2)
         ) u_dut (
            .clk(clk), .rst(rst),
            .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_di(spi_di),
            .spi_do(spi_do_w[g]), .spi_do_oe(spi_do_oe_w[g]),
            .ioctl_addr(addr_w[g]), .ioctl_rd(rd_w[g]),
            .ioctl_data2sd(d2sd_w[g]),
            .uploading(up_w[g]), .byte_cnt(cnt_w[g])
         );

         // RAM model: data for a strobe seen at edge n is on the bus LAT
         // cycles after the strobe cycle, and only then
         always @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < 8; k++) begin
                  vp[k] <= 1'b0;
                  ap[k] <= 8'd0;
               end
            end else begin
               vp[0] <= rd_w[g];
               ap[0] <= addr_w[g][7:0];
               for (int k = 1; k < 8; k++) begin
                  vp[k] <= vp[k-1];
                  ap[k] <= ap[k-1];
               end
            end
         end
         assign d2sd_w[g] = vp[LAT-1] ? mem[ap[LAT-1]] : 8'hE7;
      end
   endgenerate

   always @(posedge clk) if (rd_w[0]) rd_cnt <= rd_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Master side of nb bits, MSB first. spi_do is sampled late in the high
   // phase since the slave reacts to SCK falls through its synchroniser.
   task automatic spi_bits(input logic [7:0] tx, input int nb);
      for (int i = 7; i > 7 - nb; i--) begin
         spi_di = tx[i];
         #20 spi_sck = 1'b1;
         #19;
         for (int g = 0; g < 3; g++) rxb[g][i] = spi_do_w[g];
         oe_seen = oe_seen | spi_do_oe_w[0];
         up_all  = up_all & up_w[0];
         #1 spi_sck = 1'b0;
      end
   endtask

   task automatic select_and_cmd(input logic [7:0] cmd);
      spi_ss = 1'b0;
      #40;
      oe_seen = 1'b0;
      spi_bits(cmd, 8);
      up_all = 1'b1;
   endtask

   task automatic deselect();
      #20 spi_ss = 1'b1;
      #60;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;

      // Reset state
      #20;
      check("rst_do",   {31'd0, spi_do_w[0]},    32'd1);
      check("rst_oe",   {31'd0, spi_do_oe_w[0]}, 32'd0);
      check("rst_addr", 32'(addr_w[0]),          32'd0);
      check("rst_rd",   {31'd0, rd_w[0]},        32'd0);
      check("rst_up",   {31'd0, up_w[0]},        32'd0);
      check("rst_cnt",  32'(cnt_w[0]),           32'd0);
      rst = 1'b0;
      #40;

`ifdef JTFRAME_UPLOAD_LIMIT_EN
      // Limit at 2 bytes: two RAM bytes then padding
      select_and_cmd(8'h56);
      for (int b = 0; b < 4; b++) begin
         spi_bits(8'h00, 8);
         exp_b = (b < 2) ? mem[b] : 8'hFF;
         check($sformatf("lim_byte%0d", b), {24'd0, rxb[0]}, {24'd0, exp_b});
      end
      #40;
      check("lim_addr", 32'(addr_w[0]), 32'd2);
      check("lim_cnt",  32'(cnt_w[0]),  32'd2);
      deselect();
`else
      // Basic upload
      select_and_cmd(8'h56);
      for (int b = 0; b < 4; b++) begin
         spi_bits(8'h00, 8);
         check($sformatf("basic_byte%0d", b), {24'd0, rxb[0]}, {24'd0, mem[b]});
      end
      check("basic_up_all", {31'd0, up_all}, 32'd1);
      #40;
      check("basic_cnt",  32'(cnt_w[0]),  32'd4);
      check("basic_addr", 32'(addr_w[0]), 32'd4);
      deselect();
      check("desel_up",  {31'd0, up_w[0]},        32'd0);
      check("desel_oe",  {31'd0, spi_do_oe_w[0]}, 32'd0);
      check("desel_cnt", 32'(cnt_w[0]),           32'd4);

      // Wrong command
      rd_base = rd_cnt;
      select_and_cmd(8'h54);
      spi_bits(8'h00, 8);
      spi_bits(8'h00, 8);
      check("wrong_oe",  {31'd0, oe_seen},  32'd0);
      check("wrong_rd",  32'(rd_cnt - rd_base), 32'd1);
      check("wrong_up",  {31'd0, up_w[0]},  32'd0);
      check("wrong_do",  {31'd0, spi_do_w[0]}, 32'd1);
      deselect();

      // Abort three bits into the second data byte
      select_and_cmd(8'h56);
      spi_bits(8'h00, 8);
      check("abort_byte0", {24'd0, rxb[0]}, {24'd0, mem[0]});
      spi_bits(8'h00, 3);
      #10 spi_ss = 1'b1;
      #30;
      check("abort_up",  {31'd0, up_w[0]}, 32'd0);
      check("abort_cnt", 32'(cnt_w[0]),   32'd1);
      #40;
      spi_ss = 1'b0;
      #40;
      check("restart_addr", 32'(addr_w[0]), 32'd0);
      oe_seen = 1'b0;
      spi_bits(8'h56, 8);
      spi_bits(8'h00, 8);
      check("restart_byte0", {24'd0, rxb[0]}, {24'd0, mem[0]});
      deselect();

      // Latency sweep: 16 random bytes on all three instances
      for (int i = 0; i < 17; i++) mem[i] = 8'($urandom_range(0, 255));
      select_and_cmd(8'h56);
      for (int b = 0; b < 16; b++) begin
         spi_bits(8'h00, 8);
         check($sformatf("lat2_byte%0d", b), {24'd0, rxb[0]}, {24'd0, mem[b]});
         check($sformatf("lat1_byte%0d", b), {24'd0, rxb[1]}, {24'd0, mem[b]});
         check($sformatf("lat7_byte%0d", b), {24'd0, rxb[2]}, {24'd0, mem[b]});
      end
      #40;
      check("sweep_cnt7", 32'(cnt_w[2]), 32'd16);
      deselect();

      // Async reset in the middle of SEND
      select_and_cmd(8'h56);
      spi_bits(8'h00, 8);
      spi_bits(8'h00, 4);
      check("pre_rst_oe", {31'd0, spi_do_oe_w[0]}, 32'd1);
      rst = 1'b1;
      #1;
      check("arst_do", {31'd0, spi_do_w[0]},    32'd1);
      check("arst_oe", {31'd0, spi_do_oe_w[0]}, 32'd0);
      check("arst_rd", {31'd0, rd_w[0]},        32'd0);
      check("arst_up", {31'd0, up_w[0]},        32'd0);
      #9 spi_ss = 1'b1;
      #40 rst = 1'b0;
      #40;
      select_and_cmd(8'h56);
      spi_bits(8'h00, 8);
      check("post_rst_byte0", {24'd0, rxb[0]}, {24'd0, mem[0]});
      spi_bits(8'h00, 8);
      check("post_rst_byte1", {24'd0, rxb[0]}, {24'd0, mem[1]});
      deselect();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
